pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
// - Producer of the 6-bit pipeline stall bus `CtrlBus` consumed by the pc/if_id/id_ex/ex_mem/mem_wb registers.
// - Merges two stall sources: a level request from ID (load-use) and a level request from EX.
// - Also owns a self-timed countdown for multi-cycle EX ops (div/madd), so EX only pulses a start with a length.
// - Tracks stall statistics and raises a sticky watchdog error on stall lock-up.
// PARAMETERS
// - CNT_W       6    width of ex_mc_len and of the internal countdown
// - WDOG_LIMIT  255  consecutive stalled cycles that set wdog_err
// - PERF_W      32   width of the saturating total-stall-cycle counter
// PORTS
// - clk           in   1       clock, all state on posedge
// - rst           in   1       reset, synchronous, active-high (`RstEnable)
// - stallreq_id   in   1       ID requests stall (level)
// - stallreq_ex   in   1       EX requests stall (level)
// - ex_mc_start   in   1       one-cycle pulse: EX begins a multi-cycle op
// - ex_mc_len     in   CNT_W   total stall cycles for that op, sampled with ex_mc_start
// - stall         out  6       bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; `STOP=1
// - mc_busy       out  1       multi-cycle op in progress (start cycle through last stall cycle)
// - mc_done       out  1       high in the final stall cycle of a multi-cycle op
// - stall_total   out  PERF_W  cycles with stall!=0 since reset, saturates at all-ones
// - wdog_err      out  1       sticky lock-up flag
// BEHAVIOUR
// - stall, mc_busy and mc_done are combinational from registered state plus current inputs; zero-latency, same-cycle.
// - During rst: stall=6'b000000, mc_busy=0, mc_done=0. Next state: state=RUN, cnt=0, stall_total=0, wdog_run=0, wdog_err=0.
// - Encodings: EX stall=6'b001111; ID stall=6'b000111; none=6'b000000. Priority: EX over ID.
// - EX stall is active when stallreq_ex, or state==MC_BUSY, or (state==RUN && ex_mc_start && ex_mc_len!=0).
// - FSM RUN:
//   - ex_mc_start with len==0: ignored, no stall.
//   - len==1: one stall cycle, mc_done=1 that cycle, stay RUN.
//   - len>=2: stall this cycle, cnt<=len-1, go to MC_BUSY.
// - FSM MC_BUSY:
//   - Stall each cycle; cnt<=cnt-1.
//   - When cnt==1: mc_done=1, next state RUN.
//   - An op with len=N therefore stalls exactly N consecutive cycles, starting with the start cycle.
// - ex_mc_start while in MC_BUSY is ignored; the count is not reloaded.
// - A new start is accepted in the first RUN cycle after mc_done. Back-to-back ops are allowed.
// - stall_total increments every cycle stall!=0, saturating.
// - wdog_run counts consecutive stalled cycles and clears on any unstalled cycle.
// - wdog_err sets when wdog_run reaches WDOG_LIMIT and holds until rst. The stall bus is not affected.
// - rst mid-op: the op is abandoned and the next cycle is RUN with no stall.
// CONFIGURATION
// - Macro PIPE_STALL_CTRL_FLUSH_EN adds input `flush` (1b) and output `flush_o` (1b).
// - With the macro defined:
//   - flush has top priority: stall=0, flush_o=1 in the same cycle.
//   - state<=RUN, cnt<=0, any in-flight multi-cycle op is cancelled with no mc_done.
//   - A same-cycle ex_mc_start is dropped.
//   - wdog_run clears; the flush cycle is not counted in stall_total.
// - Without the macro: no flush ports; behaviour is identical to flush tied 0.
// STRUCTURE
// - Shared header precompiled.v: `CtrlBus, `STOP/`NOSTOP, `RstEnable.
//   - New entries: `STALL_NONE 6'b000000, `STALL_FROM_ID 6'b000111, `STALL_FROM_EX 6'b001111.
//   - State encodings: `PSC_RUN, `PSC_MC_BUSY.
// - One sub-module, pipe_mc_counter: load/decrement countdown (CNT_W).
//   - Ports: load, len, dec, cnt, last (cnt==1).
// - The FSM, priority mux, perf counter and watchdog stay in pipe_stall_ctrl.
// TESTING
// - rst held 3 cycles with stallreq_id=1: stall=000000 throughout; stall_total=0, wdog_err=0 after release.
// - ID stall:
//   - stallreq_id=1 for 2 cycles: stall=000111 both cycles, stall_total=2.
//   - stallreq_id=1 and stallreq_ex=1 together: stall=001111.
// - Multi-cycle op, ex_mc_start with len=4:
//   - stall=001111 for exactly 4 cycles; mc_busy high for those 4.
//   - mc_done only in the 4th; 5th cycle stall=000000.
//   - A second start in cycle 2 is ignored.
// - Multi-cycle length edges:
//   - len=0: no stall, mc_busy=0.
//   - len=1: one stall cycle with mc_done=1.
//   - Back-to-back len=2 then len=3 (second start the cycle after done): 5 stall cycles total.
// - Watchdog, WDOG_LIMIT=8: stallreq_ex held 8 cycles -> wdog_err=1 on the 9th cycle, still 1 after the request drops.
// - FLUSH_EN: len=6 op, flush in 3rd stall cycle -> stall=000000 and flush_o=1 that cycle, mc_done never asserted, mc_busy=0 next cycle.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl_pkg
//  Description : Shared stall-bus encodings, stall-controller state type and
//                the stall priority encoder used by pipe_stall_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_stall_ctrl_pkg;

    // One bit per pipeline register: bit0 pc ... bit5 wb; a set bit stops it
    localparam logic       c_STOP        = 1'b1;
    localparam logic       c_NOSTOP      = 1'b0;
    localparam logic [5:0] c_STALL_NONE    = 6'b000000;
    localparam logic [5:0] c_STALL_FROM_ID = 6'b000111;
    localparam logic [5:0] c_STALL_FROM_EX = 6'b001111;

    // Controller state: free running, or counting down a multi-cycle EX op
    typedef enum logic [0:0] {
        PSC_RUN     = 1'b0,
        PSC_MC_BUSY = 1'b1
    } psc_state_t;

    // EX stall freezes one more stage than ID stall, so EX wins
    function automatic logic [5:0] stall_encode(input logic ex_req, input logic id_req);
        if (ex_req)
            return c_STALL_FROM_EX;
        else if (id_req)
            return c_STALL_FROM_ID;
        else
            return c_STALL_NONE;
    endfunction

endpackage : pipe_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_mc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mc_counter
//  Description : Load/decrement countdown for multi-cycle EX ops. Loading
//                with len stores len-1 because the start cycle is itself the
//                first stall cycle; last flags the final stall cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mc_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    // Countdown register: load takes precedence, decrement never wraps below 0
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= len - CNT_W'(1);
        else if (dec && (r_cnt != '0))
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(1));

endmodule : pipe_mc_counter
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Produces the 6-bit pipeline stall bus from the ID and EX
//                stall requests, times multi-cycle EX ops itself, counts
//                stalled cycles (saturating) and flags stall lock-up with a
//                sticky watchdog error.
//  Config      : PIPE_STALL_CTRL_FLUSH_EN - adds flush input / flush_o output;
//                flush overrides everything and cancels any in-flight op.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int WDOG_LIMIT = 255,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              ex_mc_start,
    input  logic [CNT_W-1:0]  ex_mc_len,
`ifdef PIPE_STALL_CTRL_FLUSH_EN
    input  logic              flush,
`endif
    output logic [5:0]        stall,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] stall_total,
    output logic              wdog_err
`ifdef PIPE_STALL_CTRL_FLUSH_EN
    ,
    output logic              flush_o
`endif
);

    // Watchdog run counter only needs to reach WDOG_LIMIT, where it parks
    localparam int               c_WDOG_W    = $clog2(WDOG_LIMIT + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX  = c_WDOG_W'(WDOG_LIMIT);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(WDOG_LIMIT - 1);
    localparam logic [CNT_W-1:0]    c_LEN_ONE   = CNT_W'(1);

    psc_state_t          r_state;
    psc_state_t          w_state_nxt;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_last;
    logic                w_flush;
    logic                w_hold;
    logic                w_start_ok;
    logic                w_load;
    logic                w_mc_active;
    logic                w_ex_stall;
    logic                w_stalled;
    logic [5:0]          w_stall;
    logic                w_mc_done;
    logic [PERF_W-1:0]   r_stall_total;
    logic [c_WDOG_W-1:0] r_wdog_run;
    logic                r_wdog_err;

`ifdef PIPE_STALL_CTRL_FLUSH_EN
    assign w_flush = flush;
    assign flush_o = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Reset and flush both blank the bus in the same cycle
    assign w_hold = rst || w_flush;

    // A start is only honoured from RUN with a non-zero length; a flush drops it
    assign w_start_ok  = (r_state == PSC_RUN) && ex_mc_start &&
                         (ex_mc_len != '0) && !w_flush;
    assign w_load      = w_start_ok && (ex_mc_len != c_LEN_ONE);
    assign w_mc_active = (r_state == PSC_MC_BUSY) || w_start_ok;
    assign w_ex_stall  = stallreq_ex || w_mc_active;

    pipe_mc_counter #(
        .CNT_W (CNT_W)
    ) u_mc_counter (
        .clk  (clk),
        .rst  (w_hold),
        .load (w_load),
        .len  (ex_mc_len),
        .dec  (r_state == PSC_MC_BUSY),
        .cnt  (w_cnt),
        .last (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= PSC_RUN;
        else
            r_state <= w_state_nxt;
    end

    // Next state plus the combinational stall bus and op status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = c_STALL_NONE;
        w_mc_done   = 1'b0;
        if (w_flush) begin
            w_state_nxt = PSC_RUN;
        end else begin
            w_stall = stall_encode(w_ex_stall, stallreq_id);
            case (r_state)
                PSC_RUN: begin
                    if (w_start_ok && (ex_mc_len == c_LEN_ONE))
                        w_mc_done = 1'b1;
                    else if (w_load)
                        w_state_nxt = PSC_MC_BUSY;
                end
                PSC_MC_BUSY: begin
                    if (w_last) begin
                        w_mc_done   = 1'b1;
                        w_state_nxt = PSC_RUN;
                    end
                end
                default: w_state_nxt = PSC_RUN;
            endcase
        end
        if (rst) begin
            w_stall   = c_STALL_NONE;
            w_mc_done = 1'b0;
        end
    end

    assign stall     = w_stall;
    assign mc_busy   = w_mc_active && !w_hold;
    assign mc_done   = w_mc_done;
    assign w_stalled = (w_stall != c_STALL_NONE);

    // Saturating count of cycles with any stage stalled
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_total <= '0;
        else if (w_stalled && (r_stall_total != '1))
            r_stall_total <= r_stall_total + PERF_W'(1);
    end

    // Consecutive-stall run length; error latches on the LIMIT-th stalled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_run <= '0;
            r_wdog_err <= 1'b0;
        end else if (w_stalled) begin
            if (r_wdog_run != c_WDOG_MAX)
                r_wdog_run <= r_wdog_run + c_WDOG_W'(1);
            if (r_wdog_run >= c_WDOG_LAST)
                r_wdog_err <= 1'b1;
        end else begin
            r_wdog_run <= '0;
        end
    end

    assign stall_total = r_stall_total;
    assign wdog_err    = r_wdog_err;

endmodule : pipe_stall_ctrl
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl: directed scenarios
//                followed by random traffic, all compared against a
//                cycle-level reference model built on a remaining-cycles
//                count of the active multi-cycle op.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int c_CNT_W  = 6;
    localparam int c_WDOG   = 8;
    localparam int c_PERF_W = 6;
    localparam int c_PERF_MAX = (1 << c_PERF_W) - 1;

    logic               clk;
    logic               rst;
    logic               stallreq_id;
    logic               stallreq_ex;
    logic               ex_mc_start;
    logic [c_CNT_W-1:0] ex_mc_len;
    logic               flush;
    logic [5:0]         stall;
    logic               mc_busy;
    logic               mc_done;
    logic [c_PERF_W-1:0] stall_total;
    logic               wdog_err;
`ifdef PIPE_STALL_CTRL_FLUSH_EN
    logic               flush_o;
`endif

    pipe_stall_ctrl #(
        .CNT_W      (c_CNT_W),
        .WDOG_LIMIT (c_WDOG),
        .PERF_W     (c_PERF_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .ex_mc_start (ex_mc_start),
        .ex_mc_len   (ex_mc_len),
`ifdef PIPE_STALL_CTRL_FLUSH_EN
        .flush       (flush),
`endif
        .stall       (stall),
        .mc_busy     (mc_busy),
        .mc_done     (mc_done),
        .stall_total (stall_total),
        .wdog_err    (wdog_err)
`ifdef PIPE_STALL_CTRL_FLUSH_EN
        ,
        .flush_o     (flush_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_rem   = 0;   // stall cycles still owed to the current op
    int m_total = 0;
    int m_run   = 0;
    bit m_err   = 1'b0;

    int n_done  = 0;   // mc_done pulses seen since last clear
    int n_stall = 0;   // stalled cycles seen since last clear

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model
    task automatic cycle(input bit r, input bit id, input bit ex,
                         input bit st, input int ln, input bit fl);
        logic [5:0] e_stall;
        bit e_busy, e_done, active;
        @(negedge clk);
        rst         = r;
        stallreq_id = id;
        stallreq_ex = ex;
        ex_mc_start = st;
        ex_mc_len   = c_CNT_W'(ln);
        flush       = fl;
        e_stall = 6'b000000;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        active  = 1'b0;
        if (!r && !fl) begin
            if (m_rem == 0 && st && ln > 0)
                m_rem = ln;
            active  = (m_rem > 0);
            e_busy  = active;
            e_done  = (m_rem == 1);
            e_stall = (ex || active) ? 6'b001111 : (id ? 6'b000111 : 6'b000000);
        end
        #1;
        chk("stall", 64'(stall), 64'(e_stall));
        chk("mc_busy", 64'(mc_busy), 64'(e_busy));
        chk("mc_done", 64'(mc_done), 64'(e_done));
        chk("stall_total", 64'(stall_total), 64'(m_total));
        chk("wdog_err", 64'(wdog_err), 64'(m_err));
`ifdef PIPE_STALL_CTRL_FLUSH_EN
        chk("flush_o", 64'(flush_o), 64'(fl));
`endif
        if (mc_done) n_done++;
        if (stall != 6'b000000) n_stall++;
        // Register updates at the coming edge
        if (r) begin
            m_rem = 0; m_total = 0; m_run = 0; m_err = 1'b0;
        end else if (fl) begin
            m_rem = 0; m_run = 0;
        end else begin
            if (active) m_rem--;
            if (e_stall != 6'b000000) begin
                if (m_total < c_PERF_MAX) m_total++;
                m_run++;
                if (m_run >= c_WDOG) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b0; stallreq_ex = 1'b0;
        ex_mc_start = 1'b0; ex_mc_len = '0; flush = 1'b0;

        // Reset held 3 cycles with an ID request pending
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
        idle(1);

        // ID stall for two cycles, then ID+EX together
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("total_after_id2", 64'(stall_total), 64'd2);
        cycle(0, 1, 1, 0, 0, 0);
        idle(1);

        // len=4 op with a second start in its 2nd cycle
        n_done = 0; n_stall = 0;
        cycle(0, 0, 0, 1, 4, 0);
        cycle(0, 0, 0, 1, 7, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("len4_stall_cycles", 64'(n_stall), 64'd4);
        chk("len4_done_pulses", 64'(n_done), 64'd1);

        // len=0 ignored, len=1 single cycle
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0);
        idle(1);

        // Back-to-back len=2 then len=3
        n_stall = 0;
        cycle(0, 0, 0, 1, 2, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 0);
        idle(3);
        chk("b2b_stall_cycles", 64'(n_stall), 64'd5);

        // Watchdog: EX held 8 cycles from a clean reset
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, 0, 0);
        idle(2);
        chk("wdog_sticky", 64'(wdog_err), 64'd1);

`ifdef PIPE_STALL_CTRL_FLUSH_EN
        // len=6 op flushed in its 3rd stall cycle
        cycle(1, 0, 0, 0, 0, 0);
        n_done = 0;
        cycle(0, 0, 0, 1, 6, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 2, 1);
        idle(6);
        chk("flush_no_done", 64'(n_done), 64'd0);
`endif

        // Reset mid-op abandons it
        cycle(0, 0, 0, 1, 9, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bit r, id, ex, st, fl;
            int ln;
            r  = ($urandom_range(0, 119) == 0);
            id = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 4) == 0);
            ln = $urandom_range(0, 7);
            fl = 1'b0;
`ifdef PIPE_STALL_CTRL_FLUSH_EN
            fl = ($urandom_range(0, 24) == 0);
`endif
            cycle(r, id, ex, st, ln, fl);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pipe_stall_ctrl
`default_nettype wire
